// File: rtl/jtframe_dwnld_pkg.sv
// rtl/jtframe_dwnld_pkg.sv - shared types and constants for the download packer
// Byte-mask encodings, output FSM states and the FIFO entry layout.
package jtframe_dwnld_pkg;

  localparam logic [1:0] MASK_FULL = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  typedef struct packed {
    logic [1:0]  bank;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } entry_t;

  // Lone byte as {data, mask}; the byte lands in the half selected by lane and swab
  function automatic logic [17:0] part_word(input logic lane, input logic [7:0] d,
                                            input logic swab);
    if (lane ^ swab) return {d, 8'h00, MASK_HI};
    else             return {8'h00, d, MASK_LO};
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// rtl/jtframe_dwnld_fifo.sv - first-word-fall-through synchronous FIFO
// A write while full is accepted only if a read frees a slot in the same cycle.
module jtframe_dwnld_fifo #(
  parameter int AW = 3,
  parameter int DW = 42
)(
  input  logic          rst,
  input  logic          clk,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign full  = count[AW];
  assign empty = (count == '0);
  assign wr_en = wr & (~full | rd);
  assign rd_en = rd & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// rtl/jtframe_dwnld_pack.sv - packs the download byte stream into masked SDRAM words
// Header strip, bank mapping, byte pairing, FIFO buffering and the request/ack FSM.
module jtframe_dwnld_pack
  import jtframe_dwnld_pkg::*;
#(
  parameter int          HEADER    = 0,
  parameter logic [26:0] BA1_START = 27'h0,
  parameter logic [26:0] BA2_START = 27'h0,
  parameter logic [26:0] BA3_START = 27'h0,
  parameter int          AW        = 3,
  parameter bit          SWAB      = 1'b0
)(
  input  logic        rst,
  input  logic        clk,
  input  logic        downloading,
  input  logic        ioctl_rom_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        dwnld_done,
  output logic        overflow
);

  localparam logic [26:0] HDR      = 27'(HEADER);
  localparam logic [AW:0] WAIT_LVL = (AW+1)'((1 << AW) - 2);

  logic        dl_q, rise;
  logic        hdr_ok, wr_ok, in1, in2, in3;
  logic [26:0] a;
  logic [22:0] start, w;
  logic [1:0]  bank;
  logic [21:0] waddr;
  logic        lane;

  logic        h_valid, h_lane, hval, same, seen;
  logic [1:0]  h_bank;
  logic [21:0] h_addr;
  logic [7:0]  h_data, ev_b, od_b;

  logic        push, pop, load, full, empty, drop;
  entry_t      push_e, head;
  logic [AW:0] count;
  state_t      state, state_nx;

  assign rise = downloading & ~dl_q;

  // Compares against start-1 so a zero parameter folds to a constant false
  assign hdr_ok = (HEADER == 0) || (ioctl_addr > HDR - 27'd1);
  assign wr_ok  = ioctl_rom_wr & hdr_ok;
  assign a      = ioctl_addr - HDR;
  assign in1    = (BA1_START != 27'd0) && (a > BA1_START - 27'd1);
  assign in2    = (BA2_START != 27'd0) && (a > BA2_START - 27'd1);
  assign in3    = (BA3_START != 27'd0) && (a > BA3_START - 27'd1);

  always_comb begin
    bank  = 2'd0;
    start = 23'd0;
    if (in3) begin
      bank  = 2'd3;
      start = BA3_START[22:0];
    end else if (in2) begin
      bank  = 2'd2;
      start = BA2_START[22:0];
    end else if (in1) begin
      bank  = 2'd1;
      start = BA1_START[22:0];
    end
  end

  assign w     = a[22:0] - start;
  assign waddr = w[22:1];
  assign lane  = w[0];

  // A held byte does not survive the start of a new download
  assign hval = h_valid & ~rise;
  assign same = hval && (h_bank == bank) && (h_addr == waddr) && (h_lane != lane);
  assign ev_b = h_lane ? ioctl_dout : h_data;
  assign od_b = h_lane ? h_data : ioctl_dout;

  always_comb begin
    push   = 1'b0;
    push_e = '0;
    if (wr_ok && same) begin
      push        = 1'b1;
      push_e.bank = h_bank;
      push_e.addr = h_addr;
      push_e.data = SWAB ? {ev_b, od_b} : {od_b, ev_b};
      push_e.mask = MASK_FULL;
    end else if ((wr_ok || !downloading) && hval) begin
      push        = 1'b1;
      push_e.bank = h_bank;
      push_e.addr = h_addr;
      {push_e.data, push_e.mask} = part_word(h_lane, h_data, SWAB);
    end
  end

  assign drop = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q     <= 1'b0;
      h_valid  <= 1'b0;
      h_bank   <= 2'd0;
      h_addr   <= 22'd0;
      h_lane   <= 1'b0;
      h_data   <= 8'd0;
      seen     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (wr_ok) begin
        seen    <= 1'b1;
        h_valid <= ~same;
        h_bank  <= bank;
        h_addr  <= waddr;
        h_lane  <= lane;
        h_data  <= ioctl_dout;
      end else if (rise || !downloading) begin
        h_valid <= 1'b0;
      end
      if (rise)      overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  jtframe_dwnld_fifo #(.AW(AW), .DW(42)) u_fifo (
    .rst   (rst),
    .clk   (clk),
    .wr    (push),
    .din   (push_e),
    .rd    (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign ioctl_wait = (count >= WAIT_LVL);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        load     = 1'b1;
        state_nx = REQ;
      end
      REQ: if (prog_rdy) begin
        pop      = 1'b1;
        state_nx = GAP;
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prog_we    <= 1'b0;
      prog_addr  <= 22'd0;
      prog_data  <= 16'd0;
      prog_mask  <= 2'b11;
      prog_bank  <= 2'd0;
      dwnld_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        prog_we   <= 1'b1;
        prog_bank <= head.bank;
        prog_addr <= head.addr;
        prog_data <= head.data;
        prog_mask <= head.mask;
      end else if (pop) begin
        prog_we <= 1'b0;
      end
      dwnld_done <= ~downloading & empty & ~h_valid & (state == IDLE) & seen;
    end
  end

endmodule

// File: doc/jtframe_dwnld_pack.md
Name: jtframe_dwnld_pack

Overview:
- Sits directly downstream of the MiSTer download front-end.
- Consumes its byte stream (ioctl_rom_wr / ioctl_addr / ioctl_dout / downloading).
- Strips an optional header, maps byte addresses onto four SDRAM banks, and packs byte pairs into 16-bit masked words.
- Buffers the words in a small FIFO and issues them to the SDRAM controller through a request/ack handshake. Back-pressure is returned as ioctl_wait.

Parameters:
HEADER, 0, bytes at the start of the stream that are discarded
BA1_START, 27'h0, first byte address (after header removal) mapped to bank 1
BA2_START, 27'h0, first byte address mapped to bank 2
BA3_START, 27'h0, first byte address mapped to bank 3
AW, 3, FIFO depth is 2**AW entries
SWAB, 0, 1 = even byte goes to prog_data[15:8]

Ports:
rst  in  1  asynchronous reset, active high
clk  in  1  clock
downloading  in  1  download active
ioctl_rom_wr  in  1  one-cycle byte write strobe
ioctl_addr  in  27  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  back-pressure to the HPS side
prog_we  out  1  SDRAM write request, held until ack
prog_rdy  in  1  SDRAM ack, one cycle
prog_addr  out  22  word address within the bank
prog_data  out  16  write data
prog_mask  out  2  active-high byte mask; bit0 set = low byte not written
prog_bank  out  2  SDRAM bank
dwnld_done  out  1  all data written
overflow  out  1  sticky: a byte was lost

Behaviour:
- Reset (asynchronous, rst high) clears every output to 0, except prog_mask, which resets to 2'b11.
- Reset also empties the FIFO and clears the held-byte register. A reset in mid-transfer abandons everything.
- Rising edge of downloading clears the held byte and overflow. FIFO contents are kept.
- Address mapping, applied on ioctl_rom_wr:
  - a = ioctl_addr - HEADER. If ioctl_addr < HEADER, the byte is ignored.
  - bank = 3 if a >= BA3_START and BA3_START != 0; else 2 or 1 by the same rule; else 0.
  - w = a - start(bank) (start(0) = 0). Word address = w[22:1].
- Packing, with one held-byte register {valid, bank, waddr, lane, data}:
  - Byte with the same bank and word address as the held byte, opposite lane: push a full word, mask 2'b00, and clear held.
  - Byte with a different word, or the same lane: push the held byte as a partial word, then hold the new byte.
    - Even lane alone gives mask 2'b10; odd lane alone gives mask 2'b01.
    - The unused data byte is 0.
  - Falling edge of downloading with held valid: push the held byte as a partial word on the next cycle.
- FIFO:
  - Entries are {bank, addr, data, mask}; at most one push per cycle.
  - ioctl_wait = 1 while occupancy >= 2**AW - 2. It updates one cycle after the push/pop.
  - A push into a full FIFO is dropped and sets overflow.
  - Simultaneous push and pop keeps occupancy unchanged.
- Output FSM:
  - IDLE: when the FIFO is not empty, load the head onto prog_* and set prog_we. Go to REQ.
  - REQ: hold prog_* stable until prog_rdy = 1. In that cycle, pop; on the next edge clear prog_we and go to GAP.
  - GAP: one idle cycle, then IDLE.
  - Minimum spacing is 3 cycles per word.
  - A prog_rdy while in IDLE or GAP is ignored.
- dwnld_done = 1 when all of these hold:
  - downloading = 0;
  - FIFO empty;
  - held byte invalid;
  - FSM in IDLE;
  - at least one byte accepted since reset.
- dwnld_done falls in the cycle after downloading rises.

Decomposition:
- Package jtframe_dwnld_pkg holds:
  - mask constants MASK_FULL = 2'b00, MASK_LO = 2'b10, MASK_HI = 2'b01;
  - FSM state enum {IDLE, REQ, GAP};
  - the FIFO entry struct.
- One sub-module: jtframe_dwnld_fifo, a synchronous FIFO with parameter AW, DW = 42, outputs full/empty/count, first-word-fall-through.

Test Plan:
- Bytes 0x11@0, 0x22@1 with prog_rdy after 2 cycles -> one request: bank 0, addr 0, data 16'h2211, mask 00. dwnld_done asserts after downloading falls.
- HEADER = 64; bytes @0..63 then 0xAA@64 -> the first 64 bytes produce nothing. Word 0 gets data 16'h00AA, mask 10, pushed on the downloading fall.
- BA1_START = 27'h100000; byte 0x5A@0x100003 (no header) -> bank 1, addr 1, mask 01, data 16'h5A00.
- 32 bytes in consecutive cycles, prog_rdy held 0 -> ioctl_wait rises at occupancy 6. The 9th word is dropped and overflow = 1. Releasing ack drains 8 words in order.
- rst pulse while prog_we = 1 with 4 queued -> prog_we = 0 and the FIFO is empty immediately. No further requests follow.
- Same-lane repeat: 0x01@2, 0x02@2 -> two partial words at addr 1, mask 10, data 16'h0001 then 16'h0002.
